// File: rtl/clock_divider_prog.sv
// clock_divider_prog: N-channel programmable clock and tick generator.
// New period/high settings are staged and applied only at wrap or while disabled.
module clock_divider_prog #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CNT_W = 32,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = 5_000_000,
  parameter logic [CNT_W-1:0] DEFAULT_HIGH = 2_500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*CNT_W-1:0] cfg_period,
  input  logic [N_CH*CNT_W-1:0] cfg_high,
  input  logic [N_CH-1:0]       cfg_load,
  output logic [N_CH-1:0]       cfg_pending,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_p_q, act_p_d;
    logic [CNT_W-1:0] act_h_q, act_h_d;
    logic [CNT_W-1:0] pend_p_q, pend_p_d;
    logic [CNT_W-1:0] pend_h_q, pend_h_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] req_p, req_h;
    logic [CNT_W-1:0] per, per_m1, hi;
    logic             start, at_wrap, step_c, apply;

    assign req_p = cfg_period[i*CNT_W +: CNT_W];
    assign req_h = cfg_high[i*CNT_W +: CNT_W];

    // A zero period behaves as one; high time saturates at the period.
    assign per    = (act_p_q == '0) ? ONE : act_p_q;
    assign per_m1 = per - ONE;
    assign hi     = (act_h_q > per) ? per : act_h_q;

    assign start   = en[i] && (st_q == ST_IDLE);
    assign at_wrap = en[i] && (st_q == ST_RUN) && (cnt_q == per_m1);
    assign step_c  = en[i] && (st_q == ST_RUN) && (cnt_q != per_m1);
    assign apply   = at_wrap || !en[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q     <= ST_IDLE;
        cnt_q    <= '0;
        act_p_q  <= DEFAULT_PERIOD;
        act_h_q  <= DEFAULT_HIGH;
        pend_p_q <= '0;
        pend_h_q <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        st_q     <= st_d;
        cnt_q    <= cnt_d;
        act_p_q  <= act_p_d;
        act_h_q  <= act_h_d;
        pend_p_q <= pend_p_d;
        pend_h_q <= pend_h_d;
        pend_q   <= pend_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    always_comb begin
      st_d = en[i] ? ST_RUN : ST_IDLE;
    end

    // Same-edge load wins over an older staged value.
    always_comb begin
      act_p_d  = act_p_q;
      act_h_d  = act_h_q;
      pend_p_d = pend_p_q;
      pend_h_d = pend_h_q;
      pend_d   = pend_q;
      if (apply) begin
        if (cfg_load[i]) begin
          act_p_d = req_p;
          act_h_d = req_h;
        end else if (pend_q) begin
          act_p_d = pend_p_q;
          act_h_d = pend_h_q;
        end
        pend_d = 1'b0;
      end else if (cfg_load[i]) begin
        pend_p_d = req_p;
        pend_h_d = req_h;
        pend_d   = 1'b1;
      end
    end

    always_comb begin
      cnt_d  = '0;
      tick_d = 1'b0;
      clk_d  = 1'b0;
      unique case (1'b1)
        !en[i]: begin
          cnt_d = '0;
        end
        start: begin
          tick_d = 1'b1;
          clk_d  = (act_h_q != '0);
        end
        at_wrap: begin
          tick_d = 1'b1;
          clk_d  = (act_h_d != '0);
        end
        step_c: begin
          cnt_d = cnt_q + ONE;
          clk_d = ((cnt_q + ONE) < hi);
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    assign cfg_pending[i] = pend_q;
    assign clk_out[i]     = clk_q;
    assign tick[i]        = tick_q;
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: table vectors, directed corners and
// random stimulus against a period-age reference model.
module tb_clock_divider_prog;

  localparam int N = 4;
  localparam int W = 32;
  localparam int DP = 10;
  localparam int DH = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] en, cfg_load;
  logic [N-1:0] cfg_pending, clk_out, tick;
  logic [N*W-1:0] cfg_period, cfg_high;

  always #5 clk = ~clk;

  clock_divider_prog #(
    .N_CH(N),
    .CNT_W(W),
    .DEFAULT_PERIOD(DP),
    .DEFAULT_HIGH(DH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .cfg_period(cfg_period),
    .cfg_high(cfg_high),
    .cfg_load(cfg_load),
    .cfg_pending(cfg_pending),
    .clk_out(clk_out),
    .tick(tick)
  );

  int checks = 0;
  int errors = 0;

  int m_p[N], m_h[N], m_pp[N], m_ph[N], m_age[N];
  bit m_pend[N], m_run[N], m_tick[N], m_clk[N];

  typedef struct {
    int p;
    int h;
    int exp_hi;
    int exp_tk;
  } duty_vec_t;

  duty_vec_t vt[7];

  function automatic int eff_p(int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic int eff_h(int p, int h);
    return (h > eff_p(p)) ? eff_p(p) : h;
  endfunction

  task automatic check(input string name, input int ch,
                       input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0d expected %0d (t=%0t)",
               name, ch, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_p[i] = DP;
      m_h[i] = DH;
      m_pend[i] = 1'b0;
      m_run[i] = 1'b0;
      m_age[i] = 0;
      m_tick[i] = 1'b0;
      m_clk[i] = 1'b0;
    end
  endtask

  task automatic take_cfg(input int i, input bit ld,
                          input int lp, input int lh);
    if (ld) begin
      m_p[i] = lp;
      m_h[i] = lh;
    end else if (m_pend[i]) begin
      m_p[i] = m_pp[i];
      m_h[i] = m_ph[i];
    end
    m_pend[i] = 1'b0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int lp;
      int lh;
      bit ld;
      bit wrap;
      lp = int'(cfg_period[i*W +: W]);
      lh = int'(cfg_high[i*W +: W]);
      ld = cfg_load[i];
      wrap = 1'b0;
      if (!en[i]) begin
        take_cfg(i, ld, lp, lh);
        m_run[i] = 1'b0;
        m_age[i] = 0;
        m_tick[i] = 1'b0;
        m_clk[i] = 1'b0;
      end else begin
        if (!m_run[i]) begin
          m_run[i] = 1'b1;
          m_age[i] = 0;
        end else if (m_age[i] + 1 == eff_p(m_p[i])) begin
          wrap = 1'b1;
          m_age[i] = 0;
          take_cfg(i, ld, lp, lh);
        end else begin
          m_age[i]++;
        end
        if (ld && !wrap) begin
          m_pend[i] = 1'b1;
          m_pp[i] = lp;
          m_ph[i] = lh;
        end
        m_tick[i] = (m_age[i] == 0);
        m_clk[i] = (m_age[i] < eff_h(m_p[i], m_h[i]));
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check("model_clk_out", i, int'(clk_out[i]), int'(m_clk[i]));
      check("model_tick", i, int'(tick[i]), int'(m_tick[i]));
      check("model_pending", i, int'(cfg_pending[i]), int'(m_pend[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_cfg(input int ch, input int p, input int h);
    cfg_period[ch*W +: W] = W'(p);
    cfg_high[ch*W +: W] = W'(h);
  endtask

  initial begin
    int hi;
    int tk;
    int n;
    int pc;
    bit found;
    bit glitch;
    bit pseen;
    int cnt[N];
    bit et[4];
    bit ec[4];

    vt[0] = '{p: 4, h: 1, exp_hi: 5, exp_tk: 5};
    vt[1] = '{p: 4, h: 0, exp_hi: 0, exp_tk: 5};
    vt[2] = '{p: 4, h: 7, exp_hi: 20, exp_tk: 5};
    vt[3] = '{p: 0, h: 1, exp_hi: 20, exp_tk: 20};
    vt[4] = '{p: 5, h: 2, exp_hi: 8, exp_tk: 4};
    vt[5] = '{p: 1, h: 0, exp_hi: 0, exp_tk: 20};
    vt[6] = '{p: 10, h: 10, exp_hi: 20, exp_tk: 2};
    et = '{1'b1, 1'b0, 1'b0, 1'b1};
    ec = '{1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b1;
    en = '0;
    cfg_load = '0;
    cfg_period = '0;
    cfg_high = '0;
    model_reset();
    #2 rst_n = 1'b0;

    // Reset and defaults
    for (int k = 0; k < 3; k++) step();
    check("reset_clk_out", 0, int'(clk_out), 0);
    check("reset_tick", 0, int'(tick), 0);
    check("reset_pending", 0, int'(cfg_pending), 0);
    rst_n = 1'b1;
    en[0] = 1'b1;
    step();
    check("start_tick", 0, int'(tick[0]), 1);
    check("start_clk", 0, int'(clk_out[0]), 1);
    hi = 1;
    tk = 1;
    for (int k = 1; k < 20; k++) begin
      step();
      hi += int'(clk_out[0]);
      tk += int'(tick[0]);
    end
    check("default_high", 0, hi, 10);
    check("default_ticks", 0, tk, 2);

    // Duty extremes on ch1, applied while disabled
    for (int v = 0; v < 7; v++) begin
      en[1] = 1'b0;
      cfg_load[1] = 1'b1;
      set_cfg(1, vt[v].p, vt[v].h);
      step();
      cfg_load[1] = 1'b0;
      en[1] = 1'b1;
      hi = 0;
      tk = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        hi += int'(clk_out[1]);
        tk += int'(tick[1]);
      end
      check("duty_high", v, hi, vt[v].exp_hi);
      check("duty_ticks", v, tk, vt[v].exp_tk);
    end

    // Boundary application on ch0
    en[0] = 1'b0;
    cfg_load[0] = 1'b1;
    set_cfg(0, 10, 5);
    step();
    cfg_load[0] = 1'b0;
    en[0] = 1'b1;
    step();
    for (int k = 0; k < 4; k++) step();
    cfg_load[0] = 1'b1;
    set_cfg(0, 3, 2);
    step();
    cfg_load[0] = 1'b0;
    pc = int'(cfg_pending[0]);
    glitch = clk_out[0];
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tick[0]) begin
        found = 1'b1;
        break;
      end
      pc += int'(cfg_pending[0]);
      glitch |= clk_out[0];
    end
    check("bnd_wrap_found", 0, int'(found), 1);
    check("bnd_pending_cycles", 0, pc, 5);
    check("bnd_no_glitch", 0, int'(glitch), 0);
    check("bnd_pending_clear", 0, int'(cfg_pending[0]), 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      check("bnd_new_tick", k, int'(tick[0]), int'(et[k]));
      check("bnd_new_clk", k, int'(clk_out[0]), int'(ec[k]));
    end

    // Same-edge load at wrap (ch0 now at cnt 0 of a 3-cycle period)
    step();
    step();
    cfg_load[0] = 1'b1;
    set_cfg(0, 6, 3);
    step();
    cfg_load[0] = 1'b0;
    check("wrap_load_tick", 0, int'(tick[0]), 1);
    check("wrap_load_pending", 0, int'(cfg_pending[0]), 0);
    hi = int'(clk_out[0]);
    pseen = cfg_pending[0];
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      n++;
      pseen |= cfg_pending[0];
      if (tick[0]) begin
        found = 1'b1;
        break;
      end
      hi += int'(clk_out[0]);
    end
    check("wrap_load_found", 0, int'(found), 1);
    check("wrap_load_period", 0, n, 6);
    check("wrap_load_high", 0, hi, 3);
    check("wrap_load_no_pend", 0, int'(pseen), 0);

    // P=0 on ch2, disable and re-enable
    en[2] = 1'b0;
    cfg_load[2] = 1'b1;
    set_cfg(2, 0, 1);
    step();
    cfg_load[2] = 1'b0;
    en[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("p0_tick", 2, int'(tick[2]), 1);
      check("p0_clk", 2, int'(clk_out[2]), 1);
    end
    en[2] = 1'b0;
    step();
    check("dis_tick", 2, int'(tick[2]), 0);
    check("dis_clk", 2, int'(clk_out[2]), 0);
    en[2] = 1'b1;
    step();
    check("reen_tick", 2, int'(tick[2]), 1);

    // Independence: periods 2/3/5/7
    en = '0;
    cfg_load = '1;
    set_cfg(0, 2, 1);
    set_cfg(1, 3, 1);
    set_cfg(2, 5, 1);
    set_cfg(3, 7, 1);
    step();
    cfg_load = '0;
    en = '1;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 210; k++) begin
      step();
      for (int i = 0; i < N; i++) cnt[i] += int'(tick[i]);
    end
    check("indep_ticks", 0, cnt[0], 105);
    check("indep_ticks", 1, cnt[1], 70);
    check("indep_ticks", 2, cnt[2], 42);
    check("indep_ticks", 3, cnt[3], 30);

    // Async reset mid-run drops outputs and pending config
    step();
    cfg_load[3] = 1'b1;
    set_cfg(3, 4, 2);
    step();
    cfg_load[3] = 1'b0;
    check("pre_rst_pending", 3, int'(cfg_pending[3]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_clk_out", 0, int'(clk_out), 0);
    check("async_tick", 0, int'(tick), 0);
    check("async_pending", 0, int'(cfg_pending), 0);
    model_reset();
    compare_all();
    step();
    step();
    rst_n = 1'b1;
    hi = 0;
    tk = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      hi += int'(clk_out[3]);
      tk += int'(tick[3]);
    end
    check("post_rst_high", 3, hi, 10);
    check("post_rst_ticks", 3, tk, 2);

    // Random stimulus against the model
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
        cfg_load[i] = ($urandom_range(0, 7) == 0);
        set_cfg(i, int'($urandom_range(0, 9)), int'($urandom_range(0, 12)));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
# clock_divider_prog

Multi-channel, runtime-programmable clock/tick generator. It supersedes the fixed-ratio divider. Each channel derives a divided clock with programmable period and duty cycle from the single system clock, and emits a one-cycle tick at the start of every period. New settings are applied glitch-free at period boundaries. Timers, UART baud generation, LED blinkers and debug slow-clocks in the core instantiate it as their timebase.

## Interface
- N_CH, 4, number of independent channels
- CNT_W, 32, width of the period/high counters
- DEFAULT_PERIOD, 5_000_000, period in clk cycles loaded at reset (50 MHz to 10 Hz)
- DEFAULT_HIGH, 2_500_000, high time in clk cycles loaded at reset (50 % duty)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  N_CH  per-channel run enable
- cfg_period  in  N_CH*CNT_W  requested period; channel i at [i*CNT_W +: CNT_W]
- cfg_high  in  N_CH*CNT_W  requested high time, same packing
- cfg_load  in  N_CH  one-cycle strobe; captures channel i's cfg_period/cfg_high
- cfg_pending  out  N_CH  captured settings not yet applied
- clk_out  out  N_CH  divided clock, registered
- tick  out  N_CH  one-cycle pulse at each period start, registered

## Operation
- Per-channel state: cnt (CNT_W), act_p/act_h (active period/high), pend_p/pend_h, pend flag, running flag.
- Effective period P = (act_p == 0) ? 1 : act_p. Effective high time H = act_h, saturating at P. H >= P gives constant high; H == 0 gives constant low.
- cfg_load[i] copies the channel's cfg_period/cfg_high into pend_p/pend_h and sets pend. A second load before application overwrites; only the last load counts.
- Apply point: the wrap edge (running, en=1, cnt == P-1), or any edge with en=0.
  - At an apply point, pend values (or the same-edge cfg_load values, which take priority) move to act_p/act_h and pend clears.
  - The next period uses the new P/H.
- en[i]=0 at an edge: cnt<=0, clk_out<=0, tick<=0, running<=0.
- en[i]=1 with running=0 (start edge): cnt<=0, running<=1, tick<=1, clk_out<=(H>0).
- en[i]=1 with running=1:
  - If cnt == P-1: cnt<=0, tick<=1, clk_out<=(H'>0), where H'/P' are the post-apply values.
  - Otherwise: cnt<=cnt+1, tick<=0, clk_out<=(cnt+1 < H).
- Invariant after each edge while running: clk_out == (cnt < H) and tick == (cnt == 0 just entered).
- Comparisons are unsigned CNT_W-bit. cnt never exceeds P-1, so there is no wrap-around beyond the period.
- If act_p shrinks below the current cnt, this cannot happen mid-period, because values are applied only at wrap or while disabled.
- Channels are fully independent and share only clk/rst_n.

## Timing
- Reset (async assert, sync to clk on deassert by the system):
  - all outputs 0; cnt=0; running=0; pend=0.
  - act_p=DEFAULT_PERIOD, act_h=DEFAULT_HIGH for every channel.
- Start latency: tick and clk_out (if H>0) go high on the first rising edge that samples en=1.
- Period: tick repeats every P clk cycles; clk_out is high for exactly min(H,P) cycles per period.
- P=1: tick is constantly 1 while running. clk_out is constantly 1 if H>=1.
- cfg_pending rises the edge after cfg_load and falls on the apply edge. If load and apply coincide, cfg_pending stays 0.
- Disable takes effect on the next edge. No partial high pulse survives a disable, and re-enable restarts the period from cnt=0.
- Mid-operation reset: outputs drop asynchronously with rst_n low. Pending configuration is lost.

## Test plan
- Reset/defaults: with DEFAULT_PERIOD=10 and DEFAULT_HIGH=5, hold rst_n low, then enable ch0 -> tick every 10 cycles, clk_out high 5 and low 5; all outputs 0 during reset.
- Duty/extremes: ch1 loaded with P=4,H=1, then H=0, then H=7 (each applied while disabled) -> 1-of-4 high, constant low, constant high; tick every 4 cycles in all three cases.
- Boundary application: ch0 running P=10; cfg_load P=3,H=2 at cnt=4 -> cfg_pending high for 5 cycles, old period completes, then a 3-cycle period with 2 high; no glitch on clk_out.
- Same-edge load at wrap: cfg_load P=6,H=3 on the cnt==P-1 edge -> applied immediately, cfg_pending never rises, next period is 6 cycles.
- P=0/1 and disable: ch2 P=0,H=1 -> tick and clk_out constant 1; deassert en mid-period -> both 0 on the next edge; reassert -> tick the first cycle, cnt restarts at 0.
- Independence plus async reset: all 4 channels with periods 2/3/5/7 run 210 cycles, and tick counts match 105/70/42/30; pulse rst_n mid-run -> all outputs 0 immediately and defaults restored.
